// File: rtl/burst_collector_pkg.sv
// burst_collector shared types: FSM state encoding and burst counter width.
// Imported by burst_collector and burst_collector_fifo.
package burst_collector_pkg;

  localparam int COUNTER_WIDTH = 8;

  typedef enum logic [1:0] {
    STATE_IDLE,
    STATE_ACTIVE,
    STATE_DONE
  } state_t;

endpackage

// File: rtl/burst_collector_fifo.sv
// Synchronous FIFO: push/pop, combinational head word, registered level.
// Ports: clk, rst, push, pop, wdata, rdata (head), level (occupancy).
module burst_collector_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/burst_collector.sv
// Buffers an unstallable word stream and re-emits fixed-length bursts
// on valid/ready with a last marker; flush drains a partial burst.
// Ports: clk, rst, data_in/in_valid, flush, out_data/out_valid/
// out_ready/out_last, level, overflow (sticky drop flag).
// Option BURST_COLLECTOR_STATS_EN adds drop_count[7:0] (saturating).
module burst_collector
  import burst_collector_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int BURST_LEN = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       in_valid,
  input  logic                       flush,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow
`ifdef BURST_COLLECTOR_STATS_EN
  ,
  output logic [7:0]                 drop_count
`endif
);

  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] BURST_L = LW'(BURST_LEN);

  state_t                   state, state_d;
  logic [COUNTER_WIDTH-1:0] cnt, cnt_d;
  logic                     flush_pend, flush_d;
  logic                     push, pop;
  logic [WIDTH-1:0]         head;

  burst_collector_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (data_in),
    .rdata (head),
    .level (level)
  );

  // Outputs come from registered state only; out_data is zeroed
  // outside a burst so it is defined after reset.
  assign out_valid = (state == STATE_ACTIVE);
  assign out_last  = out_valid && (cnt == COUNTER_WIDTH'(1));
  assign out_data  = out_valid ? head : '0;
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle frees a slot for a full FIFO.
  assign push      = in_valid && ((level != DEPTH_L) || pop);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    flush_d = flush_pend;
    unique case (state)
      STATE_IDLE: begin
        if (level >= BURST_L) begin
          state_d = STATE_ACTIVE;
          cnt_d   = COUNTER_WIDTH'(BURST_LEN);
          flush_d = 1'b0;
        end else if (flush_pend && level != '0) begin
          state_d = STATE_ACTIVE;
          cnt_d   = COUNTER_WIDTH'(level);
          flush_d = 1'b0;
        end else if (level == '0) begin
          flush_d = 1'b0;
        end
      end
      STATE_ACTIVE: begin
        if (pop) begin
          cnt_d = cnt - 1'b1;
          if (out_last) state_d = STATE_DONE;
        end
      end
      STATE_DONE: state_d = STATE_IDLE;
      default:    state_d = STATE_IDLE;
    endcase
    // A new request always survives, even one arriving as the
    // previous one is consumed.
    if (flush) flush_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= STATE_IDLE;
      cnt        <= '0;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      flush_pend <= flush_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) overflow <= 1'b0;
    else if (in_valid && !push) overflow <= 1'b1;
  end

`ifdef BURST_COLLECTOR_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) drop_count <= '0;
    else if (in_valid && !push && drop_count != 8'hFF)
      drop_count <= drop_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_burst_collector.sv
// Scoreboard bench for burst_collector: expected words queued on write,
// compared on each accepted output word.
module tb_burst_collector;
  import burst_collector_pkg::*;

  logic       clk = 0;
  logic       rst = 1;
  logic [7:0] data_in = '0;
  logic       in_valid = 0;
  logic       flush = 0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 0;
  logic       out_last;
  logic [4:0] level;
  logic       overflow;
`ifdef BURST_COLLECTOR_STATS_EN
  logic [7:0] drop_count;
`endif

  int total = 0;
  int bad = 0;
  logic [8:0] sb [$];
  logic       hold = 0;
  logic [7:0] hold_d;

  always #5 clk = ~clk;

  burst_collector dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .level     (level),
    .overflow  (overflow)
`ifdef BURST_COLLECTOR_STATS_EN
    ,
    .drop_count(drop_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] d, input bit keep,
                    input bit last);
    @(posedge clk) #1;
    in_valid = 1;
    data_in  = d;
    if (keep) sb.push_back({last, d});
  endtask

  task automatic wr_end();
    @(posedge clk) #1;
    in_valid = 0;
  endtask

  task automatic pulse_flush();
    @(posedge clk) #1 flush = 1;
    @(posedge clk) #1 flush = 0;
  endtask

  task automatic wait_sb(input int left);
    int n = 0;
    while (sb.size() > left && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), left);
  endtask

  always @(negedge clk) begin
    logic [8:0] e;
    if (rst) begin
      hold = 0;
    end else begin
      if (hold && out_valid) chk("hold", out_data, hold_d);
      hold = 0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_extra", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("data", out_data, e[7:0]);
          chk("last", out_last, e[8]);
        end
      end else if (out_valid) begin
        hold   = 1;
        hold_d = out_data;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);

    // basic burst and its exact timing
    out_ready = 1;
    for (int i = 0; i < 4; i++) wr(8'h11 + 8'(i), 1, i == 3);
    wr_end();
    @(negedge clk);
    chk("t1_level", level, 4);
    chk("t1_pre", out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_valid", out_valid, 1);
      chk("t1_lastpos", out_last, i == 3);
    end
    @(negedge clk);
    chk("t1_gap", out_valid, 0);
    chk("t1_sb", sb.size(), 0);

    // partial burst drained by flush
    wr(8'h21, 1, 0);
    wr(8'h22, 1, 1);
    wr_end();
    repeat (3) @(negedge clk);
    chk("t2_idle", out_valid, 0);
    chk("t2_level", level, 2);
    pulse_flush();
    @(negedge clk);
    chk("t2_n1", out_valid, 0);
    @(negedge clk);
    chk("t2_n2", out_valid, 1);
    wait_sb(0);
    repeat (2) @(negedge clk);
    chk("t2_empty", level, 0);

    // ready toggling during a burst
    out_ready = 0;
    for (int i = 0; i < 4; i++) wr(8'h41 + 8'(i), 1, i == 3);
    wr_end();
    for (int n = 0; n < 40 && sb.size() != 0; n++)
      @(posedge clk) #1 out_ready = ~out_ready;
    chk("t4_sb", sb.size(), 0);
    out_ready = 0;
    repeat (3) @(negedge clk);

    // overflow: 17 writes, no consumer
    for (int i = 0; i < 17; i++)
      wr(8'h30 + 8'(i), i < 16, (i % 4) == 3);
    wr_end();
    @(negedge clk);
    chk("t3_level", level, 16);
    chk("t3_ovf", overflow, 1);
`ifdef BURST_COLLECTOR_STATS_EN
    chk("t3_drops", drop_count, 1);
`endif

    // reset while the second word of a burst is offered
    @(posedge clk) #1 out_ready = 1;
    @(posedge clk) #1 rst = 1;
    @(posedge clk) #1 rst = 0;
    sb.delete();
    out_ready = 0;
    @(negedge clk);
    chk("t6_valid", out_valid, 0);
    chk("t6_last", out_last, 0);
    chk("t6_level", level, 0);
    chk("t6_ovf", overflow, 0);
    chk("t6_state", dut.state, STATE_IDLE);
`ifdef BURST_COLLECTOR_STATS_EN
    chk("t6_drops", drop_count, 0);
`endif

    // full FIFO with simultaneous write and pop
    for (int i = 0; i < 16; i++)
      wr(8'h80 + 8'(i), 1, (i % 4) == 3);
    wr_end();
    @(negedge clk);
    chk("t5_full", level, 16);
    @(posedge clk) #1;
    in_valid  = 1;
    data_in   = 8'h55;
    out_ready = 1;
    sb.push_back({1'b1, 8'h55});
    @(posedge clk) #1;
    in_valid  = 0;
    out_ready = 0;
    @(negedge clk);
    chk("t5_level", level, 16);
    chk("t5_ovf", overflow, 0);
    out_ready = 1;
    wait_sb(1);
    repeat (3) @(negedge clk);
    chk("t5_rest", level, 1);
    chk("t5_wait", out_valid, 0);
    pulse_flush();
    wait_sb(0);
    repeat (2) @(negedge clk);
    chk("t5_empty", level, 0);
    chk("t5_ovf2", overflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
